// File: rtl/tns_decoder_30.sv
// Purpose: decode a 30-bit TNS crosstalk-avoidance codeword back to its data word by weighted sum.
// Latency: 3 cycles from an accepted codeword to out_valid; throughput 1 word/cycle.
// Backpressure: the whole pipe, bubbles included, freezes while out_valid & ~out_ready; in_ready = out_ready | ~out_valid.
module tns_decoder_30 #(
    parameter int CW = 30,
    parameter int DW = 25
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic [CW-1:0] code_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] data_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          ovf
);

    // Sums carry two guard bits above the data width so the all-ones codeword cannot wrap.
    localparam int SW    = DW + 2;
    localparam int NPART = CW / 6;

    // Bit weights, bit 0 first. Group k (bits 3k-1..3k-3) holds TNSk_A/B/C; these follow the
    // tribonacci series, and bit 0 carries the residue with weight 1.
    localparam int unsigned WEIGHT [CW] = '{
        32'd1,        32'd2,        32'd4,        32'd7,        32'd13,
        32'd24,       32'd44,       32'd81,       32'd149,      32'd274,
        32'd504,      32'd927,      32'd1705,     32'd3136,     32'd5768,
        32'd10609,    32'd19513,    32'd35890,    32'd66012,    32'd121415,
        32'd223317,   32'd410744,   32'd755476,   32'd1389537,  32'd2555757,
        32'd4700770,  32'd8646064,  32'd15902591, 32'd29249425, 32'd53798080
    };

    logic          adv;
    logic          v1;
    logic          v2;
    logic          v3;
    logic [CW-1:0] code1;
    logic [SW-1:0] part2    [NPART];
    logic [SW-1:0] part_nxt [NPART];
    logic [SW-1:0] sum3;
    logic [SW-1:0] total_nxt;

    // One global advance: a stalled output holds every stage, empty ones too.
    assign adv       = out_ready | ~v3;
    assign in_ready  = adv;
    assign out_valid = v3;
    assign data_out  = sum3[DW-1:0];
    assign ovf       = |sum3[SW-1:DW];

    // Stage-2 partials: each covers two groups (six codeword bits) of the stage-1 code.
    always_comb begin
        for (int j = 0; j < NPART; j++) begin
            part_nxt[j] = '0;
            for (int b = 0; b < 6; b++) begin
                if (code1[6*j + b]) begin
                    part_nxt[j] = part_nxt[j] + SW'(WEIGHT[6*j + b]);
                end
            end
        end
    end

    // Stage-3 total of the registered partials.
    always_comb begin
        total_nxt = '0;
        for (int j = 0; j < NPART; j++) begin
            total_nxt = total_nxt + part2[j];
        end
    end

    // Pipeline registers: valids shift on advance, data loads only behind a valid word.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            code1 <= '0;
            sum3  <= '0;
            for (int j = 0; j < NPART; j++) begin
                part2[j] <= '0;
            end
        end else if (adv) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
            if (in_valid) begin
                code1 <= code_in;
            end
            if (v1) begin
                for (int j = 0; j < NPART; j++) begin
                    part2[j] <= part_nxt[j];
                end
            end
            if (v2) begin
                sum3 <= total_nxt;
            end
        end
    end

endmodule

// File: tb/tb_tns_decoder_30.sv
// Bench for tns_decoder_30: greedy tribonacci encoder and sum decoder as reference, scoreboard in order.
// Directed reset/singles/gap/backpressure/overflow cases, then a long randomized loopback stream.
// Checks handshake, stall stability, in-order data and fixed 3-cycle latency.
module tb_tns_decoder_30;

    localparam int CW = 30;
    localparam int DW = 25;

    typedef struct {
        logic [DW-1:0] d;
        logic          o;
    } exp_t;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] code_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          ovf;

    int            n_checks = 0;
    int            n_fail = 0;
    longint unsigned wt [CW];
    exp_t          q [$];
    exp_t          cur_exp;
    logic [DW-1:0] forced [$];
    logic          held = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic          prev_o = 1'b0;

    tns_decoder_30 dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .code_in   (code_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget (act=timeout req=finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference decode: plain weighted sum of set bits, then split into data and overflow.
    function automatic exp_t model_decode(input logic [CW-1:0] c);
        longint unsigned s = 0;
        exp_t e;
        for (int i = 0; i < CW; i++) if (c[i]) s += wt[i];
        e.d = DW'(s % (64'd1 << DW));
        e.o = (s >= (64'd1 << DW));
        return e;
    endfunction

    // Reference encoder: greedy tribonacci representation, largest weight first.
    function automatic logic [CW-1:0] model_encode(input longint unsigned v);
        logic [CW-1:0] c = '0;
        for (int i = CW - 1; i >= 0; i--) begin
            if (v >= wt[i]) begin
                c[i] = 1'b1;
                v -= wt[i];
            end
        end
        return c;
    endfunction

    // Per-cycle monitor: handshake rule, stall stability, and in-order scoreboard.
    always @(negedge clock) begin
        if (!rst_n) begin
            q.delete();
            held = 1'b0;
        end else begin
            chk(in_ready == (out_ready | ~out_valid), "in_ready_rule", in_ready, out_ready | ~out_valid);
            if (held) begin
                chk(out_valid == 1'b1, "stall_valid_held", out_valid, 1);
                chk(data_out == prev_d && ovf == prev_o, "stall_data_held", data_out, prev_d);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_output", data_out, -1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk(data_out == e.d, "data_out", data_out, e.d);
                    chk(ovf == e.o, "ovf", ovf, e.o);
                end
            end
            if (in_valid && in_ready) q.push_back(cur_exp);
            held   = out_valid & ~out_ready;
            prev_d = data_out;
            prev_o = ovf;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_word(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic o);
        code_in   = c;
        cur_exp.d = d;
        cur_exp.o = o;
    endtask

    // One codeword with out_ready high: out_valid must rise exactly three cycles later.
    task automatic single(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic o, input string name);
        set_word(c, d, o);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk(out_valid == 1'b0, {name, "_early"}, out_valid, 0);
        tick();
        chk(out_valid == 1'b1, {name, "_lat3"}, out_valid, 1);
        chk(data_out == d, {name, "_data"}, data_out, d);
        chk(ovf == o, {name, "_ovf"}, ovf, o);
        tick();
    endtask

    task automatic new_word(input bit raw_mix);
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        exp_t e;
        if (forced.size() != 0) begin
            d = forced.pop_front();
            set_word(model_encode(d), d, 1'b0);
        end else if (raw_mix && $urandom_range(0, 7) == 0) begin
            c = CW'($urandom);
            e = model_decode(c);
            set_word(c, e.d, e.o);
        end else begin
            d = DW'($urandom);
            set_word(model_encode(d), d, 1'b0);
        end
    endtask

    // Random stream: in_valid held until accepted, out_ready random.
    task automatic stream(input int n, input int ready_pct, input bit raw_mix);
        int  sent = 0;
        int  budget = n * 20 + 100;
        bit  pending = 1'b0;
        while (sent < n && budget > 0) begin
            if (!pending && $urandom_range(0, 3) != 0) begin
                new_word(raw_mix);
                pending = 1'b1;
            end
            in_valid  = pending;
            out_ready = ($urandom_range(0, 99) < ready_pct);
            @(negedge clock);
            if (in_valid && in_ready) begin
                pending = 1'b0;
                sent++;
            end
            tick();
            budget--;
        end
        in_valid = 1'b0;
        chk(sent == n, "stream_budget", sent, n);
    endtask

    task automatic drain();
        int budget = 30;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && budget > 0) begin
            tick();
            budget--;
        end
        chk(q.size() == 0 && !out_valid, "drain_empty", q.size(), 0);
    endtask

    initial begin
        exp_t e;
        wt[0] = 1; wt[1] = 2; wt[2] = 4;
        for (int i = 3; i < CW; i++) wt[i] = wt[i-1] + wt[i-2] + wt[i-3];

        // Pin the reference model to hand-computed values.
        chk(wt[2] == 4, "model_tns01_a", wt[2], 4);
        chk(wt[29] == 53798080, "model_tns10_a", wt[29], 53798080);
        e = model_decode(30'h3FFFFFFF);
        chk(e.d == 25'd17234543 && e.o == 1'b1, "model_all_ones", e.d, 17234543);
        e = model_decode(model_encode(25'h1FFFFFF));
        chk(e.d == 25'h1FFFFFF && e.o == 1'b0, "model_roundtrip_max", e.d, 25'h1FFFFFF);

        repeat (3) @(posedge clock);
        #1;
        chk(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
        chk(data_out == '0, "reset_data_out", data_out, 0);
        chk(ovf == 1'b0, "reset_ovf", ovf, 0);
        chk(in_ready == 1'b1, "reset_in_ready", in_ready, 1);
        #2 rst_n = 1'b1;
        tick();

        // Singles with hand-computed results.
        single(30'h0, 25'd0, 1'b0, "code_zero");
        single(30'h1, 25'd1, 1'b0, "code_one");
        single(30'h4, 25'd4, 1'b0, "code_tns01_a");
        single(30'h20000000, 25'd53798080 % (1 << 25), 1'b1, "code_tns10_a");
        single(30'h3FFFFFFF, 25'd17234543, 1'b1, "code_all_ones");

        // Gapped input 1,0,1 -> out_valid 1,0,1 three cycles on.
        set_word(30'h2, 25'd2, 1'b0); in_valid = 1'b1; tick();
        in_valid = 1'b0; tick();
        set_word(30'h8, 25'd7, 1'b0); in_valid = 1'b1; tick();
        in_valid = 1'b0;
        chk(out_valid == 1'b1, "gap_out0", out_valid, 1);
        tick();
        chk(out_valid == 1'b0, "gap_out1", out_valid, 0);
        tick();
        chk(out_valid == 1'b1, "gap_out2", out_valid, 1);
        drain();

        // Backpressure: 8 back-to-back words, out_ready low for 5 cycles mid-stream.
        begin
            int idx = 0;
            for (int cyc = 0; cyc < 24; cyc++) begin
                out_ready = !(cyc >= 5 && cyc < 10);
                if (idx < 8) begin
                    set_word(model_encode(longint'(idx) * 1000 + 3), DW'(idx * 1000 + 3), 1'b0);
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                @(negedge clock);
                if (cyc == 7) chk(in_ready == 1'b0 && out_valid == 1'b1, "bp_in_ready_low", in_ready, 0);
                if (in_valid && in_ready) idx++;
                tick();
            end
            chk(idx == 8, "bp_all_accepted", idx, 8);
        end
        drain();

        // Reset with words in flight: outputs clear at once, nothing emerges afterwards.
        out_ready = 1'b1;
        set_word(model_encode(11), 25'd11, 1'b0); in_valid = 1'b1; tick();
        set_word(model_encode(22), 25'd22, 1'b0); tick();
        set_word(model_encode(33), 25'd33, 1'b0); tick();
        rst_n = 1'b0;
        #1;
        chk(out_valid == 1'b0, "midreset_out_valid", out_valid, 0);
        chk(data_out == '0, "midreset_data_out", data_out, 0);
        chk(in_ready == 1'b1, "midreset_in_ready", in_ready, 1);
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk(out_valid == 1'b0, "postreset_no_output", out_valid, 0);
        end

        // Loopback: boundary data words, then a long random stream with some raw codewords.
        forced.push_back(25'd0);
        forced.push_back(25'd1);
        forced.push_back(25'h1FFFFFF);
        stream(3, 100, 1'b0);
        drain();
        stream(10000, 75, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
